// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    localparam int SPD_W = 2;

    // Widest LED bus the entry-pattern helper can describe; callers size-cast down.
    localparam int MAX_LEDS = 64;

    // Value loaded into the LED register when a mode is entered.
    function automatic logic [MAX_LEDS-1:0] entry_pattern(input mode_t m, input int width);
        logic [MAX_LEDS-1:0] ones;
        ones = {MAX_LEDS{1'b1}} >> (MAX_LEDS - width);
        case (m)
            MODE_BLINK: entry_pattern = ones;
            MODE_CHASE: entry_pattern = MAX_LEDS'(1);
            default:    entry_pattern = '0;
        endcase
    endfunction

    // Mode sequence advanced by each mode-button press; COUNT wraps to OFF.
    function automatic mode_t mode_next(input mode_t m);
        case (m)
            MODE_OFF:   mode_next = MODE_BLINK;
            MODE_BLINK: mode_next = MODE_CHASE;
            MODE_CHASE: mode_next = MODE_COUNT;
            default:    mode_next = MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_button_debounce.sv
// Synchronises and debounces one active-low push button, flags each press.
// Latency: press pulse 2 + DEBOUNCE_CYCLES clocks after a stable raw falling edge.
// Backpressure: none; the press pulse is one cycle and is never held.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic level,
    output logic press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
        end
    end

    // Accept a new level after an unbroken run of mismatches; pulse on the falling flip only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_b;
                press <= ~sync_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Two-button LED pattern controller: mode FSM, speed index, prescaler, LED register.
// Latency: mode/led update 3 + DEBOUNCE_CYCLES clocks after a raw button press.
// Backpressure: none; presses are consumed the cycle they are flagged.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS        = 3,        // >= 2 and <= MAX_LEDS
    parameter int DEBOUNCE_CYCLES = 50000,    // >= 1
    parameter int TICK_CYCLES     = 6000000   // >= 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                button_0,
    input  logic                button_1,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode
);

    // Slowest period is TICK_CYCLES << 3, so the counter must hold up to 8*TICK_CYCLES-1.
    localparam int PS_W = $clog2(TICK_CYCLES * 8);

    logic lvl_0;
    logic lvl_1;
    logic press_raw_0;
    logic press_raw_1;
    logic press_0;
    logic press_1;

    mode_t mode_q;
    mode_t mode_d;

    logic [SPD_W-1:0]    spd;
    logic [PS_W-1:0]     ps_cnt;
    logic [PS_W-1:0]     ps_last;
    logic                tick;
    logic [NUM_LEDS-1:0] led_entry;
    logic [NUM_LEDS-1:0] led_step;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_mode (
        .clk    (clk),
        .rst_n  (rst_n),
        .button (button_0),
        .level  (lvl_0),
        .press  (press_raw_0)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_speed (
        .clk    (clk),
        .rst_n  (rst_n),
        .button (button_1),
        .level  (lvl_1),
        .press  (press_raw_1)
    );

    // A press is only honoured while its debounced level actually reads pressed.
    assign press_0 = press_raw_0 & ~lvl_0;
    assign press_1 = press_raw_1 & ~lvl_1;

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_OFF;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode next-state: one step along OFF->BLINK->CHASE->COUNT per mode press.
    always_comb begin
        mode_d = mode_q;
        if (press_0) begin
            mode_d = mode_next(mode_q);
        end
    end

    assign mode = mode_q;

    // Speed index; 2-bit counter wraps 3 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd <= '0;
        end else if (press_1) begin
            spd <= spd + SPD_W'(1);
        end
    end

    // Last prescaler count, (TICK_CYCLES << spd) - 1, formed without a wider intermediate.
    always_comb begin
        ps_last = (PS_W'(TICK_CYCLES - 1) << spd) | ((PS_W'(1) << spd) - PS_W'(1));
        tick    = (mode_q != MODE_OFF) && (ps_cnt == ps_last);
    end

    // Entry value of the mode being entered, and the per-tick step of the current mode.
    always_comb begin
        led_entry = NUM_LEDS'(entry_pattern(mode_d, NUM_LEDS));
        led_step  = '0;
        case (mode_q)
            MODE_BLINK: led_step = ~led;
            MODE_CHASE: led_step = {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
            MODE_COUNT: led_step = led + NUM_LEDS'(1);
            default:    led_step = '0;
        endcase
    end

    // Prescaler and LED register; mode press outranks speed press, which outranks a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
            led    <= '0;
        end else if (press_0) begin
            ps_cnt <= '0;
            led    <= led_entry;
        end else if (press_1) begin
            ps_cnt <= '0;
        end else if (mode_q == MODE_OFF) begin
            ps_cnt <= '0;
            led    <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
            led    <= led_step;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench: stimulus pushes expected output changes, a monitor pops on each change.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button_0;
    logic       button_1;
    logic [2:0] led;
    logic [1:0] mode;

    led_pattern_ctrl #(
        .NUM_LEDS        (3),
        .DEBOUNCE_CYCLES (4),
        .TICK_CYCLES     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .button_0 (button_0),
        .button_1 (button_1),
        .led      (led),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [1:0] m; logic [2:0] l; } exp_t;
    typedef struct { int cyc; bit p0; bit p1; } ev_t;

    exp_t exp_q[$];
    ev_t  pend[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Pattern-level reference state.
    logic [1:0] m_mode = 2'd0;
    logic [2:0] m_led  = 3'd0;
    logic [1:0] m_spd  = 2'd0;
    int         m_next = 0;

    function automatic logic [2:0] entry_of(input logic [1:0] m);
        case (m)
            2'd1:    return 3'b111;
            2'd2:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] step_of(input logic [1:0] m, input logic [2:0] l);
        case (m)
            2'd1:    return ~l;
            2'd2:    return {l[1:0], l[2]};
            2'd3:    return l + 3'd1;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Predict the DUT output at the next rising edge and queue it if it changes.
    task automatic model_step();
        int  c;
        ev_t ev;
        c = cyc + 1;
        if (pend.size() != 0 && pend[0].cyc == c) begin
            ev = pend.pop_front();
            if (ev.p1) m_spd = m_spd + 2'd1;
            if (ev.p0) begin
                m_mode = m_mode + 2'd1;
                m_led  = entry_of(m_mode);
                exp_q.push_back('{c, m_mode, m_led});
            end
            m_next = c + (8 << m_spd);
        end else if (m_mode != 2'd0 && c == m_next) begin
            m_led = step_of(m_mode, m_led);
            exp_q.push_back('{c, m_mode, m_led});
            m_next = c + (8 << m_spd);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            model_step();
            @(negedge clk);
        end
    endtask

    // Press with the given buttons for 'hold' cycles, then give the release time to settle.
    task automatic press(input bit p0, input bit p1, input int hold);
        pend.push_back('{cyc + 7, p0, p1});
        if (p0) button_0 = 1'b0;
        if (p1) button_1 = 1'b0;
        run(hold);
        button_0 = 1'b1;
        button_1 = 1'b1;
        run(8);
    endtask

    // Monitor: every observed change of {mode, led} must match the head of the queue.
    logic [4:0] mon_prev = 5'b0;
    logic       mon_en   = 1'b0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missing_change: required mode=%0d led=%b at cycle %0d, still absent at cycle %0d",
                         mon_e.m, mon_e.l, mon_e.cyc, cyc);
            end
            if ({mode, led} !== mon_prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d got mode=%0d led=%b, required no change",
                             cyc, mode, led);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.m !== mode || mon_e.l !== led) begin
                        n_fail++;
                        $display("FAIL output_change: got cycle %0d mode=%0d led=%b, required cycle %0d mode=%0d led=%b",
                                 cyc, mode, led, mon_e.cyc, mon_e.m, mon_e.l);
                    end
                end
                mon_prev = {mode, led};
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        button_0 = 1'b1;
        button_1 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_mode", int'(mode), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Idle with buttons released: nothing may change.
        run(50);

        // Bounce shorter than the debounce window is rejected.
        button_0 = 1'b0; run(2);
        button_0 = 1'b1; run(2);
        button_0 = 1'b0; run(3);
        button_0 = 1'b1; run(12);
        check("bounce_mode", int'(mode), 0);

        // Clean press into BLINK, then watch a few toggles.
        press(1'b1, 1'b0, 10);
        run(20);
        check("blink_mode", int'(mode), 1);

        // CHASE and its wrap-around.
        press(1'b1, 1'b0, 10);
        run(30);

        // COUNT, then slow down and watch a full wrap at period 16.
        press(1'b1, 1'b0, 10);
        press(1'b0, 1'b1, 10);
        run(140);
        press(1'b0, 1'b1, 10);
        press(1'b0, 1'b1, 10);
        press(1'b0, 1'b1, 10);
        run(30);

        // Back round to CHASE at speed 0, then press both buttons together.
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        run(10);
        check("pre_both_mode", int'(mode), 2);
        press(1'b1, 1'b1, 10);
        run(30);
        check("both_mode", int'(mode), 3);

        // Restore speed 0 and return to CHASE.
        press(1'b0, 1'b1, 10);
        press(1'b0, 1'b1, 10);
        press(1'b0, 1'b1, 10);
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 10);
        run(12);

        // Asynchronous reset mid-CHASE and mid-debounce, button held through release.
        button_0 = 1'b0;
        run(3);
        @(posedge clk);
        #2;
        if (m_mode != 2'd0 || m_led != 3'd0) exp_q.push_back('{cyc, 2'd0, 3'd0});
        rst_n = 1'b0;
        #1;
        check("arst_led", int'(led), 0);
        check("arst_mode", int'(mode), 0);
        m_mode = 2'd0;
        m_led  = 3'd0;
        m_spd  = 2'd0;
        pend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pend.push_back('{cyc + 7, 1'b1, 1'b0});
        run(20);
        button_0 = 1'b1;
        run(30);
        check("post_reset_mode", int'(mode), 1);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("events_consumed", pend.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
